res_stream_reader: RTL and testbench
====================================

# res_stream_reader

Reads back a rectangular window of the 16384 × 8-bit result RAM over the RAM's registered-read port and streams the pixels out through a valid/ready handshake. It sits on the result RAM's read side, opposite the distance-transform engine that fills it, and exists so that forward-pass and backward-pass results can be drained to a host or a checker without stalling on RAM timing.

## Interface
- `BASE`, default 0: first RAM address read (14-bit).
- `COUNT`, default 16384: number of pixels read per run. Legal range is 1..16384, and `BASE+COUNT` must be ≤ 16384.
- `clk` input, 1 bit: single clock. Everything is sampled on posedge.
- `reset` input, 1 bit: asynchronous, active-low.
- `start` input, 1 bit: a one-cycle request to begin a run. It is ignored while `busy` is high.
- `busy` output, 1 bit: high from the cycle after an accepted `start` until the last pixel has been accepted.
- `done` output, 1 bit: high after a run completes. It stays high until the next accepted `start` or until reset.
- `res_rd` output, 1 bit: RAM read enable.
- `res_addr` output, 14 bits: RAM read address.
- `res_di` input, 8 bits: RAM read data. The RAM samples `res_rd`/`res_addr` on negedge, so the data is valid at the next posedge.
- `out_valid` output, 1 bit: stream data valid.
- `out_ready` input, 1 bit: stream sink ready.
- `out_data` output, 8 bits: pixel value.
- `out_addr` output, 14 bits: RAM address of `out_data`.
- `out_last` output, 1 bit: high with the final pixel of the run.
- `cksum` output, 16 bits: running checksum (see Configuration).

## Operation
- FSM has four states: IDLE, READ, DRAIN, FIN.
  - IDLE → READ on `start`.
  - READ → DRAIN after the issue of read number `COUNT`.
  - DRAIN → FIN when the beat carrying `out_last` is accepted.
  - FIN → READ on `start`.
- A read issued at posedge k, with `res_rd`=1 and `res_addr`=a, is captured into the buffer at posedge k+1 together with its address a.
- Output buffer: a 2-entry FIFO holding {data, addr, last}.
  - Occupancy counts in-flight reads.
  - A read is issued in a cycle only when occupancy, after any pop in that same cycle, is less than 2.
  - With `out_ready` held at 1 this sustains one pixel per cycle.
- Addresses are issued strictly in increasing order from `BASE` to `BASE+COUNT-1`. The issue counter is 15 bits wide so that it does not wrap at 16384.
- A stream beat transfers when `out_valid` and `out_ready` are both 1. The data, address and last fields must not change while `out_valid`=1 and `out_ready`=0.
- `res_rd` is 0 whenever no read is issued, and `res_addr` holds its last value.
- A `start` pulse arriving in READ or DRAIN is dropped; it is neither queued nor does it restart the run.
- Reset asserted mid-run aborts the run immediately: the FIFO is emptied, the in-flight read is discarded, and the FSM returns to IDLE.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `res_rd`=0.
  - `res_addr`=`BASE`.
  - `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0.
  - `cksum`=0.
- Start to first read: with `start` sampled at posedge s, `res_rd` is 1 from posedge s+1 (address `BASE`).
- First beat: `out_valid` is 1 from posedge s+2.
- Throughput: with `out_ready` held at 1, a run takes `COUNT`+2 cycles from `start` to the last accepted beat.
- Completion: `done` rises, and `busy` falls, on the posedge after `out_last` is accepted.
- Back-pressure: when `out_ready` drops, at most one more read completes. No RAM data is lost or read twice.
- `COUNT`=1: a single beat is produced, with `out_last`=1.

## Configuration
- `RES_RD_CKSUM_EN` defined:
  - `cksum` accumulates the 16-bit wrap-around sum of `out_data` over accepted beats.
  - The sum clears on an accepted `start`.
  - It is final while `done`=1.
- `RES_RD_CKSUM_EN` undefined: `cksum` is tied to 0 and no accumulator is built.

## Test plan
- Full-RAM drain: preload `res_M[i]`=i[7:0]; `start` with `out_ready`=1.
  - Beats i=0..16383 carry `out_data`=i[7:0] and `out_addr`=i.
  - `out_last` appears only on addr 16383.
  - `done` is high 16386 cycles after `start`.
- Back-pressure: `BASE`=100, `COUNT`=8; toggle `out_ready` 1,0,0,1,0,1…
  - Exactly addresses 100..107 are received in order, with no duplicates.
  - Data is stable while stalled.
  - `res_rd` is never high while the FIFO is full.
- `COUNT`=1, `BASE`=16383, `res_M[16383]`=8'hA5 → one beat of A5 with `out_last`=1.
- `start` pulse at cycle 5 of a run → ignored; the run completes normally with a single `done`.
- Reset low mid-run at beat 40 → all outputs go to their reset values asynchronously.
  - A new `start` after reset restarts at `BASE`.
- With `RES_RD_CKSUM_EN`, all 16384 pixels = 8'hFF → `cksum` = 16384×255 mod 65536 = 16'hC000 at `done`.
  - Without the macro, `cksum`=0.

Source files
------------

// File: rtl/res_stream_reader.sv
// res_stream_reader: drains a window [BASE, BASE+COUNT) of the 16384 x 8 result RAM
// through its registered-read port into a valid/ready pixel stream.
// Reads are issued only when the 2-entry output buffer can absorb them, so stalls
// on the sink never lose or re-read RAM data.
// Optional feature: define RES_RD_CKSUM_EN to build the 16-bit running checksum.
module res_stream_reader #(
    parameter logic [13:0] BASE  = 14'd0,
    parameter int unsigned COUNT = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [13:0] out_addr,
    output logic        out_last,
    output logic [15:0] cksum
);

    // 15 bits so BASE+COUNT = 16384 does not wrap
    localparam logic [14:0] LAST_ISSUE = 15'(BASE) + 15'(COUNT) - 15'd1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t      state;
    logic [14:0] iss_addr;
    logic        rd_last;

    logic        skid_valid;
    logic [7:0]  skid_data;
    logic [13:0] skid_addr;
    logic        skid_last;

    logic        pop;
    logic        accept_start;
    logic        issue;
    logic [1:0]  occ_after_pop;

    // Handshake, start acceptance and read-issue decision
    always_comb begin
        pop           = out_valid & out_ready;
        accept_start  = start & ((state == IDLE) || (state == FIN));
        // buffered beats plus the read still in flight, less this cycle's pop
        occ_after_pop = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, res_rd} - {1'b0, pop};
        issue         = (state == READ) && (occ_after_pop < 2'd2);
    end

    // Run control FSM and RAM read issue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            res_rd   <= 1'b0;
            res_addr <= BASE;
            iss_addr <= 15'(BASE);
            rd_last  <= 1'b0;
        end else begin
            res_rd <= issue;
            if (issue) begin
                res_addr <= iss_addr[13:0];
                rd_last  <= (iss_addr == LAST_ISSUE);
                iss_addr <= iss_addr + 15'd1;
            end
            case (state)
                IDLE, FIN: begin
                    if (accept_start) begin
                        state    <= READ;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        iss_addr <= 15'(BASE);
                    end
                end
                READ: begin
                    if (issue && (iss_addr == LAST_ISSUE)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry output buffer: head drives the stream, skid catches the one
    // read that can still land after the sink stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_addr  <= '0;
            skid_last  <= 1'b0;
        end else if (pop) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_addr   <= skid_addr;
                out_last   <= skid_last;
                skid_valid <= res_rd;
                if (res_rd) begin
                    skid_data <= res_di;
                    skid_addr <= res_addr;
                    skid_last <= rd_last;
                end
            end else begin
                out_valid <= res_rd;
                if (res_rd) begin
                    out_data <= res_di;
                    out_addr <= res_addr;
                    out_last <= rd_last;
                end
            end
        end else if (!out_valid) begin
            out_valid <= res_rd;
            if (res_rd) begin
                out_data <= res_di;
                out_addr <= res_addr;
                out_last <= rd_last;
            end
        end else if (res_rd) begin
            skid_valid <= 1'b1;
            skid_data  <= res_di;
            skid_addr  <= res_addr;
            skid_last  <= rd_last;
        end
    end

`ifdef RES_RD_CKSUM_EN
    // Wrap-around sum of accepted pixels, cleared when a run starts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cksum <= '0;
        end else if (accept_start) begin
            cksum <= '0;
        end else if (pop) begin
            cksum <= cksum + {8'd0, out_data};
        end
    end
`else
    assign cksum = '0;
`endif

endmodule

// File: tb/tb_res_stream_reader.sv
// tb_res_stream_reader: three instances (full RAM, BASE=100/COUNT=8, BASE=16383/COUNT=1),
// each with its own negedge-sampled RAM model; a stream model derives the expected
// beat sequence directly from BASE, COUNT and RAM contents.
module tb_res_stream_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int   sel = 0;
    logic start_sel = 1'b0;
    logic ready = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic st_f, st_b, st_o, rdy_f, rdy_b, rdy_o;
    assign st_f  = start_sel && (sel == 0);
    assign st_b  = start_sel && (sel == 1);
    assign st_o  = start_sel && (sel == 2);
    assign rdy_f = ready && (sel == 0);
    assign rdy_b = ready && (sel == 1);
    assign rdy_o = ready && (sel == 2);

    logic [7:0] mem_f [16384];
    logic [7:0] mem_b [16384];
    logic [7:0] mem_o [16384];

    logic f_busy, f_done, f_rd, f_valid, f_last;
    logic [13:0] f_raddr, f_oaddr;
    logic [7:0]  f_di, f_data;
    logic [15:0] f_ck;
    logic b_busy, b_done, b_rd, b_valid, b_last;
    logic [13:0] b_raddr, b_oaddr;
    logic [7:0]  b_di, b_data;
    logic [15:0] b_ck;
    logic o_busy, o_done, o_rd, o_valid, o_last;
    logic [13:0] o_raddr, o_oaddr;
    logic [7:0]  o_di, o_data;
    logic [15:0] o_ck;

    res_stream_reader u_full (
        .clk(clk), .reset(reset), .start(st_f), .busy(f_busy), .done(f_done),
        .res_rd(f_rd), .res_addr(f_raddr), .res_di(f_di), .out_valid(f_valid),
        .out_ready(rdy_f), .out_data(f_data), .out_addr(f_oaddr), .out_last(f_last),
        .cksum(f_ck)
    );

    res_stream_reader #(.BASE(14'd100), .COUNT(8)) u_bp (
        .clk(clk), .reset(reset), .start(st_b), .busy(b_busy), .done(b_done),
        .res_rd(b_rd), .res_addr(b_raddr), .res_di(b_di), .out_valid(b_valid),
        .out_ready(rdy_b), .out_data(b_data), .out_addr(b_oaddr), .out_last(b_last),
        .cksum(b_ck)
    );

    res_stream_reader #(.BASE(14'd16383), .COUNT(1)) u_one (
        .clk(clk), .reset(reset), .start(st_o), .busy(o_busy), .done(o_done),
        .res_rd(o_rd), .res_addr(o_raddr), .res_di(o_di), .out_valid(o_valid),
        .out_ready(rdy_o), .out_data(o_data), .out_addr(o_oaddr), .out_last(o_last),
        .cksum(o_ck)
    );

    // RAM models: address sampled on negedge, data valid at the next posedge
    always @(negedge clk) if (f_rd) f_di <= mem_f[f_raddr];
    always @(negedge clk) if (b_rd) b_di <= mem_b[b_raddr];
    always @(negedge clk) if (o_rd) o_di <= mem_o[o_raddr];

    logic m_busy, m_done, m_rd, m_valid, m_last;
    logic [13:0] m_raddr, m_oaddr;
    logic [7:0]  m_data;
    logic [15:0] m_ck;

    // View of the instance currently under test
    always_comb begin
        m_busy = f_busy; m_done = f_done; m_rd = f_rd; m_raddr = f_raddr;
        m_valid = f_valid; m_data = f_data; m_oaddr = f_oaddr; m_last = f_last; m_ck = f_ck;
        if (sel == 1) begin
            m_busy = b_busy; m_done = b_done; m_rd = b_rd; m_raddr = b_raddr;
            m_valid = b_valid; m_data = b_data; m_oaddr = b_oaddr; m_last = b_last; m_ck = b_ck;
        end else if (sel == 2) begin
            m_busy = o_busy; m_done = o_done; m_rd = o_rd; m_raddr = o_raddr;
            m_valid = o_valid; m_data = o_data; m_oaddr = o_oaddr; m_last = o_last; m_ck = o_ck;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input int s, input int a);
        case (s)
            0:       return mem_f[a];
            1:       return mem_b[a];
            default: return mem_o[a];
        endcase
    endfunction

    function automatic logic [15:0] exp_ck(input logic [15:0] sum);
`ifdef RES_RD_CKSUM_EN
        return sum;
`else
        return 16'h0000 & sum;
`endif
    endfunction

    task automatic chk_reset_vals(input string tag, input logic [13:0] base);
        chk({tag, " busy"}, m_busy, 0);
        chk({tag, " done"}, m_done, 0);
        chk({tag, " res_rd"}, m_rd, 0);
        chk({tag, " res_addr"}, m_raddr, base);
        chk({tag, " out_valid"}, m_valid, 0);
        chk({tag, " out_data"}, m_data, 0);
        chk({tag, " out_addr"}, m_oaddr, 0);
        chk({tag, " out_last"}, m_last, 0);
        chk({tag, " cksum"}, m_ck, 0);
    endtask

    // mode 0: ready held 1, 1: random ready, 2: repeating 1,0,0,1,0,1
    // stop < count leaves the run in progress after that many beats
    task automatic run_stream(input int s, input int base, input int count,
                              input int mode, input int stop, input bit inject);
        int cyc, idx, rds, lim;
        logic [15:0] sum;
        logic [5:0]  pat;
        pat = 6'b101001;
        sel = s;
        lim = (stop < count) ? stop : count;
        cyc = 0; idx = 0; rds = 0; sum = '0;
        start_sel = 1'b1;
        @(posedge clk); #1;
        start_sel = 1'b0;
        while (idx < lim && cyc < count * 4 + 20) begin
            chk($sformatf("busy_in_run c%0d", cyc), m_busy, 1);
            chk($sformatf("done_in_run c%0d", cyc), m_done, 0);
            if (cyc == 0) chk("first_rd_latency c0", m_rd, 0);
            if (cyc == 1) begin
                chk("first_rd c1", m_rd, 1);
                chk("first_rd_addr c1", m_raddr, base);
            end
            if (cyc == 2) chk("first_valid c2", m_valid, 1);
            if (m_rd) begin
                // rds - idx beats are buffered right now
                chk($sformatf("rd_while_full c%0d", cyc), (rds - idx) < 2, 1);
                chk($sformatf("rd_in_window c%0d", cyc), rds < count, 1);
                chk($sformatf("rd_addr c%0d", cyc), m_raddr, base + rds);
                rds++;
            end
            if (m_valid) begin
                chk($sformatf("beat_data i%0d", idx), m_data, exp_data(s, base + idx));
                chk($sformatf("beat_addr i%0d", idx), m_oaddr, base + idx);
                chk($sformatf("beat_last i%0d", idx), m_last, (idx == count - 1));
            end
            case (mode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = pat[cyc % 6];
            endcase
            start_sel = inject && (cyc == 5);
            if (m_valid && ready) begin
                sum = sum + {8'd0, exp_data(s, base + idx)};
                idx++;
            end
            @(posedge clk); #1;
            start_sel = 1'b0;
            cyc++;
        end
        if (idx < lim) begin
            chk("run_timeout beats", idx, lim);
        end else if (stop >= count) begin
            chk("end done", m_done, 1);
            chk("end busy", m_busy, 0);
            chk("end valid", m_valid, 0);
            chk("end cksum", m_ck, exp_ck(sum));
            if (mode == 0) chk("run_cycles", cyc, count + 2);
            for (int k = 0; k < 3; k++) begin
                ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                chk($sformatf("after done%0d", k), m_done, 1);
                chk($sformatf("after busy%0d", k), m_busy, 0);
                chk($sformatf("after rd%0d", k), m_rd, 0);
                chk($sformatf("after valid%0d", k), m_valid, 0);
            end
        end
    endtask

    typedef struct {
        logic       st;
        logic       rdy;
        logic       busy;
        logic       done;
        logic       rd;
        logic       valid;
        logic       last;
        logic [7:0] data;
    } vec_t;

    initial begin
        vec_t tbl[10];
        // COUNT=1 cycle table: {start, ready} applied, then state after the edge
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        for (int i = 0; i < 16384; i++) begin
            mem_f[i] = 8'(i);
            mem_b[i] = 8'($urandom);
            mem_o[i] = 8'($urandom);
        end
        mem_o[16383] = 8'hA5;

        #2 reset = 1'b0;
        sel = 0; #1 chk_reset_vals("rst0", 14'd0);
        sel = 1; #1 chk_reset_vals("rst1", 14'd100);
        sel = 2; #1 chk_reset_vals("rst2", 14'd16383);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;

        // single-pixel window, cycle by cycle
        sel = 2;
        for (int i = 0; i < 10; i++) begin
            start_sel = tbl[i].st;
            ready     = tbl[i].rdy;
            @(posedge clk); #1;
            start_sel = 1'b0;
            chk($sformatf("tbl%0d busy", i), m_busy, tbl[i].busy);
            chk($sformatf("tbl%0d done", i), m_done, tbl[i].done);
            chk($sformatf("tbl%0d res_rd", i), m_rd, tbl[i].rd);
            chk($sformatf("tbl%0d out_valid", i), m_valid, tbl[i].valid);
            if (tbl[i].rd) chk($sformatf("tbl%0d res_addr", i), m_raddr, 16383);
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d out_data", i), m_data, tbl[i].data);
                chk($sformatf("tbl%0d out_last", i), m_last, tbl[i].last);
                chk($sformatf("tbl%0d out_addr", i), m_oaddr, 16383);
            end
        end
        chk("tbl cksum", m_ck, exp_ck(16'h00A5));

        // back-pressure pattern with a start pulse dropped mid-run
        run_stream(1, 100, 8, 2, 8, 1'b1);

        // randomized windows and ready patterns
        for (int r = 0; r < 20; r++) begin
            for (int a = 100; a < 108; a++) mem_b[a] = 8'($urandom);
            run_stream(1, 100, 8, 1, 8, 1'($urandom_range(0, 1)));
        end

        // full-RAM drain, pixel = address[7:0]
        run_stream(0, 0, 16384, 0, 16384, 1'b0);

        // full-RAM drain of 0xFF pixels (checksum wraps)
        for (int i = 0; i < 16384; i++) mem_f[i] = 8'hFF;
        run_stream(0, 0, 16384, 0, 16384, 1'b0);

        // reset mid-run after 40 beats, then restart from BASE
        run_stream(0, 0, 16384, 0, 40, 1'b0);
        #2 reset = 1'b0;
        #1 chk_reset_vals("midrun_rst", 14'd0);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        run_stream(0, 0, 16384, 0, 5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
